// File: rtl/layer2_argmax_pkg.sv
// rtl/layer2_argmax_pkg.sv - shared BNN output-stage parameters, state encoding and MAC term helper
package layer2_argmax_pkg;
  localparam int N_IN  = 48;
  localparam int N_OUT = 10;
  localparam int ACC_W = 8;
  localparam int W_W   = 2;
  localparam int B_W   = 4;
  localparam int D_W   = 2;
  localparam int IDX_W = 6;
  localparam int CLS_W = 4;
  localparam int WA_W  = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MAC     = 2'd1,
    CMP     = 2'd2,
    DONE_ST = 2'd3
  } state_e;

  // Both operands are widened before the multiply so -2 * -2 style products keep their sign.
  function automatic logic signed [ACC_W-1:0] mac_term(input logic signed [W_W-1:0] w,
                                                       input logic signed [D_W-1:0] d);
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] d_ext;
    w_ext = ACC_W'(w);
    d_ext = ACC_W'(d);
    return w_ext * d_ext;
  endfunction
endpackage

// File: rtl/layer2_argmax_argmax_unit.sv
// rtl/layer2_argmax_argmax_unit.sv - running best-score tracker; strictly-greater wins so ties keep the lower class
module argmax_unit
  import layer2_argmax_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [ACC_W-1:0] score_i,
  input  logic [CLS_W-1:0]        cls_i,
  input  logic                    valid_i,
  input  logic                    first_i,
  output logic signed [ACC_W-1:0] best_o,
  output logic [CLS_W-1:0]        best_cls_o
);
  logic signed [ACC_W-1:0] best_q;
  logic signed [ACC_W-1:0] best_d;
  logic [CLS_W-1:0]        best_cls_q;
  logic [CLS_W-1:0]        best_cls_d;
  logic                    take;

  always_comb begin
    take       = valid_i && (first_i || (score_i > best_q));
    best_d     = take ? score_i : best_q;
    best_cls_d = take ? cls_i : best_cls_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_q     <= '0;
      best_cls_q <= '0;
    end else begin
      best_q     <= best_d;
      best_cls_q <= best_cls_d;
    end
  end

  // Post-compare view so the caller can latch a result that includes the compare in flight.
  assign best_o     = best_d;
  assign best_cls_o = best_cls_d;
endmodule

// File: rtl/layer2_argmax.sv
// rtl/layer2_argmax.sv - BNN output layer: per-class bias + weight*input MAC over 48 hidden outputs, running argmax
module layer2_argmax
  import layer2_argmax_pkg::*;
#(
  parameter logic [N_IN*N_OUT*W_W-1:0] W2_ROM = '0,
  parameter logic [N_OUT*B_W-1:0]      B2_ROM = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [5:0]       l1_addr,
  input  logic [1:0]       l1_data,
  output logic             busy,
  output logic             done,
  output logic [3:0]       class_out,
  output logic [ACC_W-1:0] max_score
);
  logic signed [W_W-1:0] w2_rom [N_IN*N_OUT];
  logic signed [B_W-1:0] b2_rom [N_OUT];

  for (genvar i = 0; i < N_IN*N_OUT; i++) begin : g_w2
    assign w2_rom[i] = W2_ROM[i*W_W +: W_W];
  end
  for (genvar c = 0; c < N_OUT; c++) begin : g_b2
    assign b2_rom[c] = B2_ROM[c*B_W +: B_W];
  end

  state_e                  state_q;
  state_e                  state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        idx_d;
  logic [CLS_W-1:0]        cls_q;
  logic [CLS_W-1:0]        cls_d;
  logic [CLS_W-1:0]        class_q;
  logic [CLS_W-1:0]        class_d;
  logic signed [ACC_W-1:0] score_q;
  logic signed [ACC_W-1:0] score_d;

  logic [WA_W-1:0]         w_addr;
  logic [CLS_W-1:0]        cls_next;
  logic                    cmp_valid;
  logic                    cmp_first;
  logic signed [ACC_W-1:0] best_next;
  logic [CLS_W-1:0]        best_cls_next;

  assign w_addr   = WA_W'(cls_q) * WA_W'(N_IN) + WA_W'(idx_q);
  assign cls_next = cls_q + 1'b1;

  argmax_unit u_argmax (
    .clk        (clk),
    .rst        (rst),
    .score_i    (acc_q),
    .cls_i      (cls_q),
    .valid_i    (cmp_valid),
    .first_i    (cmp_first),
    .best_o     (best_next),
    .best_cls_o (best_cls_next)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    cls_d     = cls_q;
    class_d   = class_q;
    score_d   = score_q;
    cmp_valid = 1'b0;
    cmp_first = (cls_q == '0);
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = ACC_W'(b2_rom[0]);
          cls_d   = '0;
          idx_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + mac_term(w2_rom[w_addr], l1_data);
        if (idx_q == IDX_W'(N_IN-1)) begin
          idx_d   = '0;
          state_d = CMP;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      CMP: begin
        cmp_valid = 1'b1;
        if (cls_q != CLS_W'(N_OUT-1)) begin
          // Next class is seeded here so its first MAC follows without a bubble.
          cls_d   = cls_next;
          idx_d   = '0;
          acc_d   = ACC_W'(b2_rom[cls_next]);
          state_d = MAC;
        end else begin
          class_d = best_cls_next;
          score_d = best_next;
          state_d = DONE_ST;
        end
      end
      DONE_ST: begin
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      idx_q   <= '0;
      cls_q   <= '0;
      class_q <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      cls_q   <= cls_d;
      class_q <= class_d;
      score_q <= score_d;
    end
  end

  assign l1_addr   = (state_q == MAC) ? idx_q : '0;
  assign busy      = (state_q == MAC) || (state_q == CMP);
  assign done      = (state_q == DONE_ST);
  assign class_out = class_q;
  assign max_score = score_q;
endmodule

// File: tb/tb_layer2_argmax.sv
// tb/tb_layer2_argmax.sv - directed checks of layer2_argmax with four ROM images
module tb_layer2_argmax;
  import layer2_argmax_pkg::*;

  localparam int NW = N_IN*N_OUT*W_W;
  localparam int NB = N_OUT*B_W;
  localparam logic [NW-1:0] W_T1   = {{(2*N_IN){2'b00}}, {N_IN{2'b01}}, {(7*N_IN){2'b00}}};
  localparam logic [NW-1:0] W_ZERO = '0;
  localparam logic [NW-1:0] W_NEG1 = {(N_IN*N_OUT){2'b11}};
  localparam logic [NW-1:0] W_NEG2 = {(N_IN*N_OUT){2'b10}};
  localparam logic [NB-1:0] B_ZERO  = '0;
  localparam logic [NB-1:0] B_THREE = {N_OUT{4'h3}};
  localparam logic [NB-1:0] B_RAMP  = 40'h10FEDCBA98;
  localparam logic [NB-1:0] B_SEVEN = {N_OUT{4'h7}};

  logic             clk;
  logic             rst    [4];
  logic             start  [4];
  logic [5:0]       addr   [4];
  logic [1:0]       l1d    [4];
  logic             busy   [4];
  logic             done   [4];
  logic [3:0]       cls_o  [4];
  logic [ACC_W-1:0] score_o[4];
  logic [1:0]       mem    [4][64];

  int n_cmp = 0;
  int n_bad = 0;
  int n;

  for (genvar g = 0; g < 4; g++) begin : g_l1
    assign l1d[g] = mem[g][addr[g]];
  end

  layer2_argmax #(.W2_ROM(W_T1), .B2_ROM(B_ZERO)) u_t1 (
    .clk(clk), .rst(rst[0]), .start(start[0]), .l1_addr(addr[0]), .l1_data(l1d[0]),
    .busy(busy[0]), .done(done[0]), .class_out(cls_o[0]), .max_score(score_o[0]));
  layer2_argmax #(.W2_ROM(W_ZERO), .B2_ROM(B_THREE)) u_t2 (
    .clk(clk), .rst(rst[1]), .start(start[1]), .l1_addr(addr[1]), .l1_data(l1d[1]),
    .busy(busy[1]), .done(done[1]), .class_out(cls_o[1]), .max_score(score_o[1]));
  layer2_argmax #(.W2_ROM(W_NEG1), .B2_ROM(B_RAMP)) u_t3 (
    .clk(clk), .rst(rst[2]), .start(start[2]), .l1_addr(addr[2]), .l1_data(l1d[2]),
    .busy(busy[2]), .done(done[2]), .class_out(cls_o[2]), .max_score(score_o[2]));
  layer2_argmax #(.W2_ROM(W_NEG2), .B2_ROM(B_SEVEN)) u_t4 (
    .clk(clk), .rst(rst[3]), .start(start[3]), .l1_addr(addr[3]), .l1_data(l1d[3]),
    .busy(busy[3]), .done(done[3]), .class_out(cls_o[3]), .max_score(score_o[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic kick(input int k);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Counts edges after E0 until done; pulse_at injects a one-cycle start mid-run.
  task automatic wait_done(input int k, input int pulse_at, input bit chk_addr, output int cnt);
    cnt = 0;
    while (!done[k] && cnt < 600) begin
      if (cnt == pulse_at) begin
        start[k] = 1'b1;
        chk("class_held_midrun", cls_o[k], 7);
      end else if (cnt == pulse_at + 1) begin
        start[k] = 1'b0;
      end
      @(posedge clk);
      #1;
      cnt++;
      if (chk_addr) begin
        if (cnt == 5)  chk("addr_idx5", addr[k], 5);
        if (cnt == 47) chk("addr_idx47", addr[k], 47);
        if (cnt == 48) chk("addr_cmp", addr[k], 0);
        if (cnt == 48) chk("busy_cmp", busy[k], 1);
        if (cnt == 50) chk("addr_cls1_idx1", addr[k], 1);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst[k]   = 1'b1;
      start[k] = 1'b0;
      for (int i = 0; i < 64; i++) begin
        case (k)
          0, 2:    mem[k][i] = 2'b01;
          1:       mem[k][i] = 2'(i);
          default: mem[k][i] = 2'b11;
        endcase
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_addr", addr[0], 0);
    chk("rst_class", cls_o[0], 0);
    chk("rst_score", $signed(score_o[0]), 0);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: only class 7 has +1 weights
    kick(0);
    start[0] = 1'b0;
    chk("t1_busy_e0", busy[0], 1);
    wait_done(0, -5, 1'b1, n);
    chk("t1_latency", n, 490);
    chk("t1_class", cls_o[0], 7);
    chk("t1_score", $signed(score_o[0]), 48);
    chk("t1_busy_done", busy[0], 0);
    @(posedge clk);
    #1;
    chk("t1_idle_done", done[0], 0);

    // Test 2: all scores tie at 3
    kick(1);
    start[1] = 1'b0;
    wait_done(1, -5, 1'b0, n);
    chk("t2_latency", n, 490);
    chk("t2_class", cls_o[1], 0);
    chk("t2_score", $signed(score_o[1]), 3);

    // Test 3: scores c-56, winner class 9
    kick(2);
    start[2] = 1'b0;
    wait_done(2, -5, 1'b0, n);
    chk("t3_class", cls_o[2], 9);
    chk("t3_score", $signed(score_o[2]), -47);

    // Test 4: -2 * -1 products, tie at 103
    kick(3);
    start[3] = 1'b0;
    wait_done(3, -5, 1'b0, n);
    chk("t4_class", cls_o[3], 0);
    chk("t4_score", $signed(score_o[3]), 103);

    // Test 5: reset mid-run
    kick(0);
    start[0] = 1'b0;
    repeat (199) @(posedge clk);
    #1;
    chk("t5_busy_pre", busy[0], 1);
    rst[0] = 1'b1;
    #1;
    chk("t5_rst_busy", busy[0], 0);
    chk("t5_rst_done", done[0], 0);
    chk("t5_rst_addr", addr[0], 0);
    chk("t5_rst_class", cls_o[0], 0);
    chk("t5_rst_score", $signed(score_o[0]), 0);
    @(posedge clk);
    #1;
    chk("t5_rst_busy2", busy[0], 0);
    rst[0] = 1'b0;
    @(posedge clk);
    #1;
    kick(0);
    start[0] = 1'b0;
    wait_done(0, -5, 1'b0, n);
    chk("t5_latency", n, 490);
    chk("t5_class", cls_o[0], 7);
    @(posedge clk);
    #1;

    // Test 6: start held through done, then a mid-run start pulse
    kick(0);
    wait_done(0, -5, 1'b0, n);
    chk("t6_hold_latency", n, 490);
    repeat (20) @(posedge clk);
    #1;
    chk("t6_hold_done", done[0], 1);
    chk("t6_hold_busy", busy[0], 0);
    chk("t6_hold_class", cls_o[0], 7);
    start[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_release_done", done[0], 0);
    chk("t6_release_busy", busy[0], 0);
    kick(0);
    start[0] = 1'b0;
    wait_done(0, 100, 1'b0, n);
    chk("t6_pulse_latency", n, 490);
    chk("t6_pulse_class", cls_o[0], 7);
    chk("t6_pulse_score", $signed(score_o[0]), 48);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
